// File: rtl/lcd_refresh_ctrl.sv
// HD44780 16x2 refresh sequencer: power-up wait, four init commands, then endless two-line refresh.
// Optional macro LCD_UPDATE_GATE_EN: idle after each frame until an `update` request arrives.
module lcd_refresh_ctrl #(
  parameter int PWRUP_CYC = 1000000,
  parameter int STEP_CYC  = 50,
  parameter int EXEC_CYC  = 2500,
  parameter int CLEAR_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char,
  input  logic       update,
  output logic [4:0] index,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  typedef enum logic [2:0] {ST_PWRUP, ST_INIT, ST_LADDR, ST_FETCH, ST_CWRITE, ST_IDLE} state_t;
  typedef enum logic [1:0] {PH_A, PH_B, PH_C, PH_X} phase_t;

  localparam logic [31:0] PW_LAST   = 32'(PWRUP_CYC - 1);
  localparam logic [31:0] STEP_LAST = 32'(STEP_CYC - 1);
  localparam logic [31:0] EXEC_LAST = 32'(EXEC_CYC - 1);
  localparam logic [31:0] CLR_LAST  = 32'(CLEAR_CYC - 1);

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  step_q, step_d;
  logic [4:0]  index_q, index_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        init_done_q, init_done_d;
  logic        frame_done_q, frame_done_d;
  logic [31:0] ph_last;
  logic        in_write, ph_end, wr_done;

  function automatic logic [7:0] init_cmd(input logic [1:0] s);
    case (s)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

`ifdef LCD_UPDATE_GATE_EN
  logic pend_q, pend_d, req;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= 1'b0;
    else      pend_q <= pend_d;
  end
`else
  logic unused_update;
  assign unused_update = update;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_PWRUP;
      phase_q      <= PH_A;
      cnt_q        <= '0;
      step_q       <= '0;
      index_q      <= '0;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      index_q      <= index_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q + 32'd1;
    step_d       = step_q;
    index_d      = index_q;
    rs_d         = rs_q;
    data_d       = data_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
`ifdef LCD_UPDATE_GATE_EN
    req    = pend_q | (update & init_done_q);
    pend_d = req;
`endif
    in_write = (state_q == ST_INIT) || (state_q == ST_LADDR) || (state_q == ST_CWRITE);
    if (phase_q == PH_X) ph_last = (state_q == ST_INIT && step_q == 2'd3) ? CLR_LAST : EXEC_LAST;
    else                 ph_last = STEP_LAST;
    ph_end  = in_write && (cnt_q == ph_last);
    wr_done = ph_end && (phase_q == PH_X);

    // Phase sequencing shared by every write; wrapping X->A leaves the next write ready to start.
    if (ph_end) begin
      cnt_d = '0;
      case (phase_q)
        PH_A:    phase_d = PH_B;
        PH_B:    phase_d = PH_C;
        PH_C:    phase_d = PH_X;
        default: phase_d = PH_A;
      endcase
    end

    case (state_q)
      ST_PWRUP: if (cnt_q == PW_LAST) begin
        state_d = ST_INIT;
        phase_d = PH_A;
        cnt_d   = '0;
        step_d  = 2'd0;
        rs_d    = 1'b0;
        data_d  = init_cmd(2'd0);
      end
      ST_INIT: if (wr_done) begin
        if (step_q == 2'd3) begin
          init_done_d = 1'b1;
          state_d     = ST_LADDR;
          data_d      = 8'h80;
        end else begin
          step_d = step_q + 2'd1;
          data_d = init_cmd(step_q + 2'd1);
        end
      end
      ST_LADDR: if (wr_done) state_d = ST_FETCH;
      // The string generator needs one clk after index moves; sample on the second FETCH edge.
      ST_FETCH: if (cnt_q == 32'd1) begin
        state_d = ST_CWRITE;
        cnt_d   = '0;
        rs_d    = 1'b1;
        data_d  = char;
      end
      ST_CWRITE: if (wr_done) begin
        if (index_q == 5'd15) begin
          index_d = 5'd16;
          state_d = ST_LADDR;
          rs_d    = 1'b0;
          data_d  = 8'hC0;
        end else if (index_q == 5'd31) begin
          index_d      = 5'd0;
          frame_done_d = 1'b1;
`ifdef LCD_UPDATE_GATE_EN
          if (req) begin
            pend_d  = 1'b0;
            state_d = ST_LADDR;
            rs_d    = 1'b0;
            data_d  = 8'h80;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_LADDR;
          rs_d    = 1'b0;
          data_d  = 8'h80;
`endif
        end else begin
          index_d = index_q + 5'd1;
          state_d = ST_FETCH;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
`ifdef LCD_UPDATE_GATE_EN
        if (req) begin
          pend_d  = 1'b0;
          state_d = ST_LADDR;
          rs_d    = 1'b0;
          data_d  = 8'h80;
        end
`endif
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  assign index      = index_q;
  assign lcd_e      = (phase_q == PH_B);
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = data_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed bench for lcd_refresh_ctrl with short timing parameters; char model returns 0x40+index.
module tb_lcd_refresh_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       update = 1'b0;
  logic [7:0] char_r = 8'h00;
  logic [4:0] index;
  logic       lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
  logic [7:0] lcd_data;
  logic       prev_e = 1'b0;
  int         cyc = 0;
  int         fd_cnt = 0;
  int         total = 0;
  int         bad = 0;

  lcd_refresh_ctrl #(
    .PWRUP_CYC(10), .STEP_CYC(2), .EXEC_CYC(4), .CLEAR_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .char(char_r), .update(update),
    .index(index), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(posedge clk) char_r <= 8'h40 + {3'b000, index};

  always @(negedge clk) begin
    prev_e <= lcd_e;
    if (rst && frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(output int at);
    int n;
    n  = 0;
    at = -1;
    @(negedge clk);
    while (!(lcd_e === 1'b1 && prev_e === 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $error("FAIL rise_timeout: got no lcd_e rise, want one within 2000 clks");
    end else begin
      at = cyc;
    end
  endtask

  task automatic e_width(output int w, output int fall_at);
    w = 1;
    @(negedge clk);
    while (lcd_e === 1'b1 && w < 100) begin
      w++;
      @(negedge clk);
    end
    fall_at = cyc;
  endtask

  initial begin
    int t, w, f, n;
    logic [7:0] cmds [3];
    int         cmd_t [3];
    cmds  = '{8'h0C, 8'h06, 8'h01};
    cmd_t = '{22, 32, 42};

    repeat (3) @(negedge clk);
    check("rst_index", 32'(index), 32'd0);
    check("rst_e", 32'(lcd_e), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_rw", 32'(lcd_rw), 32'd0);
    check("rst_data", 32'(lcd_data), 32'h00);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;

    wait_rise(t);
    check("first_rise_cyc", 32'(t), 32'd12);
    check("first_cmd", 32'(lcd_data), 32'h38);
    check("first_rs", 32'(lcd_rs), 32'd0);
    check("first_rw", 32'(lcd_rw), 32'd0);
    check("first_init_done", 32'(init_done), 32'd0);
    e_width(w, f);
    check("e_high_width", 32'(w), 32'd2);

    for (int i = 0; i < 3; i++) begin
      wait_rise(t);
      check("init_cmd", 32'(lcd_data), 32'(cmds[i]));
      check("init_cmd_cyc", 32'(t), 32'(cmd_t[i]));
      check("init_cmd_rs", 32'(lcd_rs), 32'd0);
    end
    e_width(w, f);
    check("clear_init_done", 32'(init_done), 32'd0);

    wait_rise(t);
    check("clear_gap", 32'(t - f), 32'd12);
    check("line1_addr", 32'(lcd_data), 32'h80);
    check("line1_addr_cyc", 32'(t), 32'd56);
    check("line1_addr_rs", 32'(lcd_rs), 32'd0);
    check("init_done_set", 32'(init_done), 32'd1);

    for (int k = 0; k < 32; k++) begin
      if (k == 16) begin
        wait_rise(t);
        check("line2_addr", 32'(lcd_data), 32'hC0);
        check("line2_addr_rs", 32'(lcd_rs), 32'd0);
        check("line2_addr_cyc", 32'(t), 32'd258);
      end
      wait_rise(t);
      check("char_data", 32'(lcd_data), 32'(8'h40 + k));
      check("char_rs", 32'(lcd_rs), 32'd1);
      check("char_index", 32'(index), 32'(k));
      if (k == 0)  check("char0_cyc", 32'(t), 32'd68);
      if (k == 16) check("char16_cyc", 32'(t), 32'd270);
    end

    n = 0;
    while (fd_cnt == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_once", 32'(fd_cnt), 32'd1);

`ifndef LCD_UPDATE_GATE_EN
    wait_rise(t);
    check("frame2_addr", 32'(lcd_data), 32'h80);
    check("frame2_addr_cyc", 32'(t), 32'd460);
    check("frame_done_count", 32'(fd_cnt), 32'd1);
    for (int j = 0; j < 22; j++) wait_rise(t);
    check("char20_data", 32'(lcd_data), 32'h54);
    check("char20_index", 32'(index), 32'd20);
    #1 rst = 1'b0;
    #1;
    check("midrst_e", 32'(lcd_e), 32'd0);
    check("midrst_index", 32'(index), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_data", 32'(lcd_data), 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_rise(t);
    check("rerun_rise_cyc", 32'(t), 32'd12);
    check("rerun_cmd", 32'(lcd_data), 32'h38);
`else
    w = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lcd_e === 1'b1) w++;
    end
    check("idle_e_low", 32'(w), 32'd0);
    f = cyc;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    wait_rise(t);
    check("update_addr", 32'(lcd_data), 32'h80);
    check("update_start_cyc", 32'(t), 32'(f + 3));
    n = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      update = (i == 50 || i == 100 || i == 150);
      if (lcd_e === 1'b1 && prev_e === 1'b0) n++;
    end
    update = 1'b0;
    check("gated_rise_count", 32'(n), 32'd68);
    check("gated_frame_count", 32'(fd_cnt), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
